fp_div_unpack: RTL and testbench

Registered operand-unpack stage sitting directly upstream of the combinational FP32 divider `main_div`. It accepts two IEEE-754 single-precision operands over a valid/ready handshake and classifies each as zero, infinity, NaN, normal or subnormal. Subnormal mantissas are normalised one bit per cycle. The stage then presents sign, unbiased exponents and 24-bit normalised mantissas to the divider core, so the core never sees a subnormal.

---
 rtl/fp_div_pkg.sv | 55 +++++
 rtl/fp_operand_norm.sv | 26 ++
 rtl/fp_div_unpack.sv | 100 ++++++++++
 tb/tb_fp_div_unpack.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
// Shared constants, state encoding and operand-unpack helpers for the FP32 divider front end.
package fp_div_pkg;

  localparam int BIAS   = 127;
  localparam int EMIN   = -126;
  localparam int FRAC_W = 23;
  localparam int MAN_W  = 24;
  localparam int EXP_W  = 10;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t NORM = 2'd1;
  localparam state_t HOLD = 2'd2;

  typedef struct packed {
    logic signed [EXP_W-1:0] exp;
    logic [MAN_W-1:0]        man;
    logic                    zero;
    logic                    inf;
    logic                    nan;
    logic                    pending;
  } fp_unpacked_t;

  function automatic logic is_subnormal(input logic [31:0] x);
    return (x[30:23] == 8'd0) && (x[FRAC_W-1:0] != '0);
  endfunction

  // Subnormals load with the hidden bit clear and are marked pending so the
  // normaliser can left-justify them before the core sees them.
  function automatic fp_unpacked_t unpack_fp32(input logic [31:0] x);
    fp_unpacked_t u;
    logic [7:0]        e;
    logic [FRAC_W-1:0] f;
    e = x[30:23];
    f = x[FRAC_W-1:0];
    u = '0;
    if (e == 8'd0) begin
      if (f != '0) begin
        u.man     = {1'b0, f};
        u.exp     = EXP_W'(EMIN);
        u.pending = 1'b1;
      end else begin
        u.zero = 1'b1;
      end
    end else if (e == 8'hFF) begin
      if (f == '0) u.inf = 1'b1;
      else         u.nan = 1'b1;
    end else begin
      u.man = {1'b1, f};
      u.exp = {2'b00, e} - EXP_W'(BIAS);
    end
    return u;
  endfunction

endpackage

// File: rtl/fp_operand_norm.sv
// One operand's unpack register plus a single-bit-per-step normaliser for subnormals.
module fp_operand_norm
  import fp_div_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [31:0]  operand,
  input  logic         step,
  output fp_unpacked_t unpacked
);

  // Pending clears on the step that brings the leading one into bit 23.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unpacked <= '0;
    end else if (load) begin
      unpacked <= unpack_fp32(operand);
    end else if (step && unpacked.pending) begin
      unpacked.man     <= unpacked.man << 1;
      unpacked.exp     <= unpacked.exp - EXP_W'(1);
      unpacked.pending <= ~unpacked.man[MAN_W-2];
    end
  end

endmodule

// File: rtl/fp_div_unpack.sv
// Registered operand-unpack stage in front of the FP32 divider core: classifies
// both operands, normalises subnormals, and hands fields over a valid/ready pair.
module fp_div_unpack #(
  parameter int DATA_WIDTH = 32,
  parameter int EXP_W      = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sign_q,
  output logic signed [EXP_W-1:0] exp_a,
  output logic signed [EXP_W-1:0] exp_b,
  output logic [23:0]             man_a,
  output logic [23:0]             man_b,
  output logic                    zero_a,
  output logic                    inf_a,
  output logic                    nan_a,
  output logic                    zero_b,
  output logic                    inf_b,
  output logic                    nan_b
);
  import fp_div_pkg::*;

  state_t       state;
  state_t       state_next;
  state_t       load_state;
  fp_unpacked_t ua;
  fp_unpacked_t ub;
  logic         accept;
  logic         step;
  logic         done_a;
  logic         done_b;
  logic         sign_r;

  assign in_ready   = (state == IDLE) || ((state == HOLD) && out_ready);
  assign out_valid  = (state == HOLD);
  assign accept     = in_valid && in_ready;
  assign step       = (state == NORM);
  assign load_state = (is_subnormal(a) || is_subnormal(b)) ? NORM : HOLD;

  // Look ahead one shift so HOLD is entered on the same edge the last operand settles.
  assign done_a = ~(ua.pending && ~ua.man[MAN_W-2]);
  assign done_b = ~(ub.pending && ~ub.man[MAN_W-2]);

  fp_operand_norm u_norm_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .operand  (a),
    .step     (step),
    .unpacked (ua)
  );

  fp_operand_norm u_norm_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .operand  (b),
    .step     (step),
    .unpacked (ub)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = load_state;
      NORM:    if (done_a && done_b) state_next = HOLD;
      HOLD:    if (out_ready) state_next = in_valid ? load_state : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sign_r <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) sign_r <= a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1];
    end
  end

  assign sign_q = sign_r;
  assign exp_a  = ua.exp;
  assign exp_b  = ub.exp;
  assign man_a  = ua.man;
  assign man_b  = ub.man;
  assign zero_a = ua.zero;
  assign inf_a  = ua.inf;
  assign nan_a  = ua.nan;
  assign zero_b = ub.zero;
  assign inf_b  = ub.inf;
  assign nan_b  = ub.nan;

endmodule

// File: tb/tb_fp_div_unpack.sv
// Scoreboard bench for fp_div_unpack: expected fields are queued at drive time and popped at out_valid.
module tb_fp_div_unpack;

  typedef struct packed {
    logic        sign;
    logic [9:0]  ea;
    logic [9:0]  eb;
    logic [23:0] ma;
    logic [23:0] mb;
    logic [5:0]  flags;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic        sign_q;
  logic signed [9:0] exp_a;
  logic signed [9:0] exp_b;
  logic [23:0] man_a;
  logic [23:0] man_b;
  logic        zero_a, inf_a, nan_a, zero_b, inf_b, nan_b;

  int   total = 0;
  int   bad   = 0;
  res_t exp_q[$];
  int   lat_q[$];

  always #5 clk = ~clk;

  fp_div_unpack #(.DATA_WIDTH(32), .EXP_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .sign_q(sign_q),
    .exp_a(exp_a), .exp_b(exp_b), .man_a(man_a), .man_b(man_b),
    .zero_a(zero_a), .inf_a(inf_a), .nan_a(nan_a),
    .zero_b(zero_b), .inf_b(inf_b), .nan_b(nan_b)
  );

  function automatic res_t observe();
    return {sign_q, exp_a, exp_b, man_a, man_b, zero_a, inf_a, nan_a, zero_b, inf_b, nan_b};
  endfunction

  // Reference model: walks the mantissa left until the hidden bit appears.
  function automatic void model_op(input logic [31:0] x, output logic [9:0] e, output logic [23:0] m,
                                   output logic [2:0] fl, output int lz);
    int ev;
    e = '0; m = '0; fl = 3'b000; lz = 0;
    if (x[30:23] == 8'hFF) fl = (x[22:0] == 0) ? 3'b010 : 3'b001;
    else if (x[30:23] == 8'h00 && x[22:0] == 0) fl = 3'b100;
    else if (x[30:23] == 8'h00) begin
      m = {1'b0, x[22:0]}; ev = -126;
      while (m[23] == 1'b0) begin m = m << 1; ev--; lz++; end
      e = ev[9:0];
    end else begin
      m = {1'b1, x[22:0]}; ev = int'(x[30:23]) - 127; e = ev[9:0];
    end
  endfunction

  function automatic res_t model(input logic [31:0] xa, input logic [31:0] xb, output int lat);
    res_t r; logic [2:0] fa, fb; int la, lb;
    model_op(xa, r.ea, r.ma, fa, la);
    model_op(xb, r.eb, r.mb, fb, lb);
    r.sign = xa[31] ^ xb[31];
    r.flags = {fa, fb};
    lat = 1 + ((la > lb) ? la : lb);
    return r;
  endfunction

  task automatic send(input logic [31:0] xa, input logic [31:0] xb);
    @(negedge clk); a = xa; b = xb; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    #12;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || observe() !== '0) begin
      bad++; $display("[TB] FAIL reset_state: out_valid=%b in_ready=%b fields=%h, want 0/1/0", out_valid, in_ready, observe());
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_classes();
    logic [31:0] ta[4] = '{32'h38140000, 32'h4FF00800, 32'h00000180, 32'h00000001};
    logic [31:0] tb[4] = '{32'h7F800000, 32'h00000000, 32'h38140000, 32'h80000001};
    res_t tr[4] = '{
      {1'b0, -10'sd15,  10'sd0,   24'h940000, 24'h000000, 6'b000010},
      {1'b0, 10'sd32,   10'sd0,   24'hF00800, 24'h000000, 6'b000100},
      {1'b0, -10'sd141, -10'sd15, 24'hC00000, 24'h940000, 6'b000000},
      {1'b1, -10'sd149, -10'sd149, 24'h800000, 24'h800000, 6'b000000}};
    int tl[4] = '{1, 1, 16, 24};
    res_t e, o; int lat, el;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(tr[i]); lat_q.push_back(tl[i]);
      send(ta[i], tb[i]);
      wait_valid(lat);
      o = observe(); e = exp_q.pop_front(); el = lat_q.pop_front();
      total++;
      if (lat !== el) begin
        bad++; $display("[TB] FAIL latency_%0d: got %0d cycles, want %0d", i, lat, el);
      end
      total++;
      if (o !== e) begin
        bad++; $display("[TB] FAIL fields_%0d: got %h, want %h", i, o, e);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    res_t e, o, snap; int lat, el; logic stable;
    out_ready = 1'b0;
    exp_q.push_back({1'b0, -10'sd15, 10'sd0, 24'h940000, 24'h000000, 6'b000001}); lat_q.push_back(1);
    send(32'h38140000, 32'h7F818000);
    wait_valid(lat);
    o = observe(); e = exp_q.pop_front(); el = lat_q.pop_front();
    total++;
    if (lat !== el || o !== e) begin
      bad++; $display("[TB] FAIL nan_fields: got %h lat %0d, want %h lat %0d", o, lat, e, el);
    end
    snap = o; stable = 1'b1;
    a = 32'h3F800000; b = 32'h3F800000; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (observe() !== snap || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    in_valid = 1'b0;
    total++;
    if (stable !== 1'b1) begin
      bad++; $display("[TB] FAIL hold_stable: got %h ov=%b ir=%b, want %h ov=1 ir=0", observe(), out_valid, in_ready, snap);
    end
    @(negedge clk); out_ready = 1'b1; #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL ready_comb: in_ready=%b, want 1", in_ready);
    end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL consumed: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pa[3] = '{32'h3F800000, 32'hC0490FDB, 32'h7F7FFFFF};
    logic [31:0] pb[3] = '{32'h40000000, 32'h3F000000, 32'h00800000};
    res_t e, o; int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin exp_q.push_back(model(pa[i], pb[i], lat)); end
    @(negedge clk); a = pa[0]; b = pb[0]; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i < 2) begin a = pa[i+1]; b = pb[i+1]; end
      else in_valid = 1'b0;
      o = observe(); e = exp_q.pop_front();
      total++;
      if (out_valid !== 1'b1 || o !== e) begin
        bad++; $display("[TB] FAIL b2b_%0d: ov=%b got %h, want ov=1 %h", i, out_valid, o, e);
      end
    end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL b2b_drain: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_norm();
    res_t e, o; int lat, el; logic quiet;
    out_ready = 1'b1;
    exp_q.push_back(model(32'h00000001, 32'h80000001, el)); lat_q.push_back(el);
    send(32'h00000001, 32'h80000001);
    repeat (5) @(posedge clk);
    @(negedge clk); rst_n = 1'b0; #1;
    exp_q.delete(); lat_q.delete();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || man_a !== 24'h0 || exp_a !== 10'sd0) begin
      bad++; $display("[TB] FAIL reset_abort: ov=%b ir=%b man_a=%h exp_a=%0d, want 0 1 0 0", out_valid, in_ready, man_a, exp_a);
    end
    @(negedge clk); rst_n = 1'b1;
    quiet = 1'b1;
    for (int c = 0; c < 30; c++) begin @(posedge clk); #1; if (out_valid !== 1'b0) quiet = 1'b0; end
    total++;
    if (quiet !== 1'b1) begin
      bad++; $display("[TB] FAIL no_stale: out_valid rose after reset, want 0");
    end
    exp_q.push_back(model(32'hBF800000, 32'h00400000, el)); lat_q.push_back(el);
    send(32'hBF800000, 32'h00400000);
    wait_valid(lat);
    o = observe(); e = exp_q.pop_front(); el = lat_q.pop_front();
    total++;
    if (lat !== el || o !== e) begin
      bad++; $display("[TB] FAIL recover: got %h lat %0d, want %h lat %0d", o, lat, e, el);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_classes();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_norm();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
